gate_exerciser: RTL and testbench

- On-chip stimulus initiator and response checker for a single 2-input logic gate under test.
- It sweeps all four input vectors into the gate, waits a programmable settle time, and samples the gate output through a synchroniser.
- It compares each sample against a truth-table parameter, then reports pass/fail, the error count and the first failing vector.
- It sits between board-level start/status I/O and any 2-input gate instance, so gates can be checked in hardware.

---
 rtl/gate_exerciser_pkg.sv | 22 ++
 rtl/gate_exerciser_if.sv | 26 ++
 rtl/gate_exerciser_sync2.sv | 27 ++
 rtl/gate_exerciser.sv | 153 +++++++++++++++
 tb/tb_gate_exerciser.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/gate_exerciser_pkg.sv
// Shared types and constants for the 2-input gate exerciser: FSM states,
// vector width and the truth tables of the common 2-input gates.
package gate_test_pkg;

  localparam int VEC_W = 2;

  // Truth tables indexed by {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage : gate_test_pkg

// File: rtl/gate_exerciser_if.sv
// Bundle of the exerciser's board-side status/control and gate-side stimulus
// signals; master is the board/gate side, slave is the exerciser.
interface gate_exerciser_if;
  import gate_test_pkg::*;

  logic             start;
  logic             gate_a;
  logic             gate_b;
  logic             gate_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2:0]       err_count;
  logic [VEC_W-1:0] fail_vec;

  modport master (
    output start, gate_out,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, gate_out,
    output gate_a, gate_b, busy, done, pass, err_count, fail_vec
  );

endinterface : gate_exerciser_if

// File: rtl/gate_exerciser_sync2.sv
// Two-flop synchroniser bringing the asynchronous gate output into clk.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours; blocking here would
  // collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync2

// File: rtl/gate_exerciser.sv
// Sweeps {a,b} = 00..11 into a gate under test, waits SETTLE_CYCLES, samples the
// synchronised output and scores it against GATE_FN.
module gate_exerciser
  import gate_test_pkg::*;
#(
  parameter logic [3:0] GATE_FN       = TT_AND,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_count,
  output logic [VEC_W-1:0] fail_vec
);

  // The synchroniser needs two cycles plus one of margin before the sample.
  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gate_exerciser: SETTLE_CYCLES must be in 3..255");
  end

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic gate_sync;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gate_out),
    .q     (gate_sync)
  );

  state_e           state_q,  state_d;
  logic [VEC_W-1:0] vec_q,    vec_d;
  logic [7:0]       cnt_q,    cnt_d;
  logic             gate_a_q, gate_a_d;
  logic             gate_b_q, gate_b_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             pass_q,   pass_d;
  logic [2:0]       err_q,    err_d;
  logic [VEC_W-1:0] fail_q,   fail_d;

  // Outputs are registered: entering DRIVE already presents the new vector,
  // entering DONE already presents done/pass/err_count together.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred. Blocking assignments
    // here let later lines (pass_d) see the updated err_d.
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    gate_a_d = gate_a_q;
    gate_b_d = gate_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_DRIVE;
          vec_d    = '0;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
        end
      end

      ST_DRIVE: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_SAMPLE: begin
        if (gate_sync != GATE_FN[vec_q]) begin
          err_d = err_q + 3'd1;
          if (err_q == 3'd0) fail_d = vec_q;
        end
        if (vec_q == 2'd3) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d  = ST_DRIVE;
          vec_d    = vec_q + 2'd1;
          gate_a_d = vec_d[1];
          gate_b_d = vec_d[0];
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: only control flops live here, so all of them take the async
  // reset; a reset mid-sweep therefore aborts it with no done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule : gate_exerciser

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: a correct, stuck-at-0 and stuck-at-1 gate
// against an AND-table exerciser, plus an AND gate against an OR-table one.
module tb_gate_exerciser;
  import gate_test_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {G_REAL, G_STUCK0, G_STUCK1} gmode_e;
  gmode_e mode = G_REAL;

  gate_exerciser_if gx ();
  gate_exerciser_if gy ();

  // Gate under test for each exerciser.
  assign gx.gate_out = (mode == G_STUCK0) ? 1'b0 :
                       (mode == G_STUCK1) ? 1'b1 : (gx.gate_a & gx.gate_b);
  assign gy.gate_out = gy.gate_a & gy.gate_b;

  gate_exerciser #(.GATE_FN(TT_AND), .SETTLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (gx.start),
    .gate_a    (gx.gate_a),
    .gate_b    (gx.gate_b),
    .gate_out  (gx.gate_out),
    .busy      (gx.busy),
    .done      (gx.done),
    .pass      (gx.pass),
    .err_count (gx.err_count),
    .fail_vec  (gx.fail_vec)
  );

  gate_exerciser #(.GATE_FN(TT_OR), .SETTLE_CYCLES(4)) dut_or (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (gy.start),
    .gate_a    (gy.gate_a),
    .gate_b    (gy.gate_b),
    .gate_out  (gy.gate_out),
    .busy      (gy.busy),
    .done      (gy.done),
    .pass      (gy.pass),
    .err_count (gy.err_count),
    .fail_vec  (gy.fail_vec)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_gate_a"},    {7'd0, gx.gate_a},    8'd0);
    check({pfx, "_gate_b"},    {7'd0, gx.gate_b},    8'd0);
    check({pfx, "_busy"},      {7'd0, gx.busy},      8'd0);
    check({pfx, "_done"},      {7'd0, gx.done},      8'd0);
    check({pfx, "_pass"},      {7'd0, gx.pass},      8'd0);
    check({pfx, "_err_count"}, {5'd0, gx.err_count}, 8'd0);
    check({pfx, "_fail_vec"},  {6'd0, gx.fail_vec},  8'd0);
  endtask

  // Observations from one sweep; k counts rising edges after the one that
  // sampled start (k=0 is the DRIVE of vector 0).
  int         done_at;
  int         done_cnt;
  logic       busy0;
  logic [1:0] vec_seen [4];

  task automatic run_sweep(input int repulse_k);
    done_at  = -1;
    done_cnt = 0;
    @(negedge clk) gx.start = 1'b1;
    @(negedge clk) gx.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      gx.start = (k == repulse_k);
      if (k == 0) busy0 = gx.busy;
      if ((k % 6) == 0 && k < 24) vec_seen[k/6] = {gx.gate_a, gx.gate_b};
      if (gx.done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      @(negedge clk);
    end
    gx.start = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int   rise_at;
    logic busy_prev;

    gx.start = 1'b0;
    gy.start = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Correct AND gate: done 24 edges after the start edge (cycle N+25).
    mode = G_REAL;
    run_sweep(-1);
    check("and_busy_in_drive0", {7'd0, busy0}, 8'd1);
    check("and_vec0", {6'd0, vec_seen[0]}, 8'd0);
    check("and_vec1", {6'd0, vec_seen[1]}, 8'd1);
    check("and_vec2", {6'd0, vec_seen[2]}, 8'd2);
    check("and_vec3", {6'd0, vec_seen[3]}, 8'd3);
    check("and_done_latency", 8'(done_at), 8'd24);
    check("and_done_count", 8'(done_cnt), 8'd1);
    check("and_pass", {7'd0, gx.pass}, 8'd1);
    check("and_err_count", {5'd0, gx.err_count}, 8'd0);
    check("and_gates_hold_11", {6'd0, gx.gate_a, gx.gate_b}, 8'd3);
    check("and_busy_after", {7'd0, gx.busy}, 8'd0);

    // Stuck at 0: only vector 11 mismatches.
    mode = G_STUCK0;
    run_sweep(-1);
    check("sa0_pass", {7'd0, gx.pass}, 8'd0);
    check("sa0_err_count", {5'd0, gx.err_count}, 8'd1);
    check("sa0_fail_vec", {6'd0, gx.fail_vec}, 8'd3);
    check("sa0_done_count", 8'(done_cnt), 8'd1);

    // Stuck at 1: vectors 00, 01, 10 mismatch.
    mode = G_STUCK1;
    run_sweep(-1);
    check("sa1_pass", {7'd0, gx.pass}, 8'd0);
    check("sa1_err_count", {5'd0, gx.err_count}, 8'd3);
    check("sa1_fail_vec", {6'd0, gx.fail_vec}, 8'd0);

    // AND gate scored against the OR table: 01 and 10 mismatch.
    @(negedge clk) gy.start = 1'b1;
    @(negedge clk) gy.start = 1'b0;
    repeat (30) @(negedge clk);
    check("or_tt_err_count", {5'd0, gy.err_count}, 8'd2);
    check("or_tt_fail_vec", {6'd0, gy.fail_vec}, 8'd1);
    check("or_tt_pass", {7'd0, gy.pass}, 8'd0);

    // Reset during SETTLE of vector 2 (k=13..16), with errors already counted.
    mode = G_STUCK1;
    @(negedge clk) gx.start = 1'b1;
    @(negedge clk) gx.start = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_busy_before", {7'd0, gx.busy}, 8'd1);
    check("mid_vec_before", {6'd0, gx.gate_a, gx.gate_b}, 8'd2);
    check("mid_err_before", {5'd0, gx.err_count}, 8'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (gx.done) done_cnt++;
      @(negedge clk);
    end
    check("mid_no_done", 8'(done_cnt), 8'd0);
    check("mid_idle_busy", {7'd0, gx.busy}, 8'd0);
    mode = G_REAL;
    run_sweep(-1);
    check("post_reset_pass", {7'd0, gx.pass}, 8'd1);
    check("post_reset_done_latency", 8'(done_at), 8'd24);

    // start re-pulsed while busy is ignored.
    run_sweep(5);
    check("repulse_done_count", 8'(done_cnt), 8'd1);
    check("repulse_done_latency", 8'(done_at), 8'd24);

    // start held: DONE at 24, IDLE at 25, second DRIVE at 26, second DONE at 50.
    done_at   = -1;
    done_cnt  = 0;
    rise_at   = -1;
    @(negedge clk) gx.start = 1'b1;
    @(negedge clk);
    busy_prev = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (gx.busy && !busy_prev && rise_at < 0) rise_at = k;
      busy_prev = gx.busy;
      if (gx.done) begin
        done_cnt++;
        if (done_cnt == 2) done_at = k;
      end
      @(negedge clk);
    end
    gx.start = 1'b0;
    check("held_second_drive", 8'(rise_at), 8'd26);
    check("held_second_done", 8'(done_at), 8'd50);
    check("held_done_count", 8'(done_cnt), 8'd2);
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_gate_exerciser
